// File: rtl/core_boot_pkg.sv
// Shared types and constants for the core boot/configuration sequencer.
package core_boot_pkg;

  typedef enum logic [1:0] {
    CFG  = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_BOOT    = 3'd0;
  localparam logic [2:0] ADDR_MTVEC   = 3'd1;
  localparam logic [2:0] ADDR_DM_HALT = 3'd2;
  localparam logic [2:0] ADDR_DM_EXC  = 3'd3;
  localparam logic [2:0] ADDR_HART_ID = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLK_EN  = 1;
  localparam int CTRL_SCAN_CG = 2;

  localparam logic [31:0] BOOT_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FF00;

  // Addresses 0..4 hold core address/ID shadows, writable only while the core is parked.
  function automatic logic is_addr_reg(input logic [2:0] addr);
    return addr <= ADDR_HART_ID;
  endfunction

endpackage

// File: rtl/core_boot_ctrl_sat_counter.sv
// 32-bit saturating up-counter with synchronous clear and count enable.
module sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot sequencer: shadows core config inputs, sequences reset release and fetch enable.
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int          RST_HOLD_CYCLES = 8,
  parameter logic [31:0] BOOT_ADDR_RST   = 32'h0000_0080,
  parameter logic [31:0] MTVEC_RST       = 32'h0000_0000,
  parameter logic [31:0] HART_ID_RST     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic        cfg_err_o,
  output logic        core_rst_no,
  output logic        fetch_enable_o,
  output logic        pulp_clock_en_o,
  output logic        scan_cg_en_o,
  output logic [31:0] boot_addr_o,
  output logic [31:0] mtvec_addr_o,
  output logic [31:0] dm_halt_addr_o,
  output logic [31:0] dm_exception_addr_o,
  output logic [31:0] hart_id_o,
  input  logic        core_sleep_i,
  output logic [31:0] sleep_cycles_o,
  output logic [1:0]  state_o
);

  state_e     state, state_next;
  logic [7:0] hold_cnt;
  logic       xfer, ctrl_wr, start_acc, stop_acc, hold_done, reg_wr, drop;

  assign xfer      = cfg_valid_i && cfg_ready_o;
  assign ctrl_wr   = xfer && (cfg_addr_i == ADDR_CTRL);
  assign start_acc = ctrl_wr && cfg_wdata_i[CTRL_START] && (state == CFG);
  assign stop_acc  = ctrl_wr && !cfg_wdata_i[CTRL_START] && (state == RUN);
  assign hold_done = (state == HOLD) && (hold_cnt == 8'(RST_HOLD_CYCLES - 1));
  assign reg_wr    = xfer && (state == CFG) && is_addr_reg(cfg_addr_i);
  assign drop      = xfer && ((cfg_addr_i > ADDR_CTRL) ||
                              ((state == RUN) && is_addr_reg(cfg_addr_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG;
    else        state <= state_next;
  end

  // NOTE: defaulting state_next first keeps this block from inferring a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      CFG:     if (start_acc) state_next = HOLD;
      HOLD:    if (hold_done) state_next = RUN;
      RUN:     if (stop_acc)  state_next = CFG;
      default: state_next = CFG;
    endcase
  end

  // Decoded from the state flop only, so no input reaches these outputs combinationally.
  always_comb begin
    cfg_ready_o = (state != HOLD);
    core_rst_no = (state == RUN);
  end

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt            <= '0;
      fetch_enable_o      <= 1'b0;
      cfg_err_o           <= 1'b0;
      pulp_clock_en_o     <= 1'b0;
      scan_cg_en_o        <= 1'b0;
      boot_addr_o         <= BOOT_ADDR_RST;
      mtvec_addr_o        <= MTVEC_RST;
      dm_halt_addr_o      <= '0;
      dm_exception_addr_o <= '0;
      hart_id_o           <= HART_ID_RST;
    end else begin
      if (start_acc)            hold_cnt <= '0;
      else if (state == HOLD)   hold_cnt <= hold_cnt + 8'd1;

      // Follows core_rst_no by one stage but drops together with it on a stop.
      fetch_enable_o <= (state_next == RUN) && core_rst_no;
      cfg_err_o      <= drop;

      if (ctrl_wr) begin
        pulp_clock_en_o <= cfg_wdata_i[CTRL_CLK_EN];
        scan_cg_en_o    <= cfg_wdata_i[CTRL_SCAN_CG];
      end

      if (reg_wr) begin
        unique case (cfg_addr_i)
          ADDR_BOOT:    boot_addr_o         <= cfg_wdata_i & BOOT_ALIGN_MASK;
          ADDR_MTVEC:   mtvec_addr_o        <= cfg_wdata_i & MTVEC_ALIGN_MASK;
          ADDR_DM_HALT: dm_halt_addr_o      <= cfg_wdata_i;
          ADDR_DM_EXC:  dm_exception_addr_o <= cfg_wdata_i;
          default:      hart_id_o           <= cfg_wdata_i;
        endcase
      end
    end
  end

  sat_counter u_sleep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    ((state == RUN) && core_sleep_i),
    .count (sleep_cycles_o)
  );

endmodule
